camera_spi_register_file: RTL and testbench
===========================================

Name: camera_spi_register_file

Overview:
Parametrised successor of the camera SPI register decoder. Sits between the SPI opcode/operand deframer and the camera pipeline (capture control, JPEG byte buffer, metering, histogram). Adds generic channel/bin/byte-count widths, multi-byte write registers committed atomically, coherent statistics snapshots, a capture status register, and defined responses for unknown opcodes and out-of-range operand counts.

Parameters:
BYTE_COUNT_WIDTH, 16, width of bytes_available/bytes_read; multiple of 8, 8..32
NUM_CHANNELS, 3, colour channels for metering and histogram
NUM_HISTOGRAM_BINS, 8, bins per channel
OPERAND_COUNT_WIDTH, 8, width of operand_count_in
COMPRESSION_WIDTH, 4, width of compression_factor_out

Ports:
clock_in  in  1  system clock
reset_in  in  1  synchronous, active-high reset
op_code_in  in  8  current opcode
op_code_valid_in  in  1  high for the whole transaction
operand_in  in  8  write operand byte
operand_valid_in  in  1  high while operand_in is valid; one rising edge per byte
operand_count_in  in  OPERAND_COUNT_WIDTH  byte index within transaction, 0-based
response_out  out  8  read response byte
response_valid_out  out  1  response_out valid
start_capture_out  out  1  one-cycle capture pulse
capture_busy_in  in  1  capture/compression in progress
compression_factor_out  out  COMPRESSION_WIDTH  compression setting
zoom_factor_out  out  16  zoom setting
pan_level_out  out  16  pan setting
bytes_available_in  in  BYTE_COUNT_WIDTH  bytes in image buffer
data_in  in  8  image byte at address bytes_read_out
bytes_read_out  out  BYTE_COUNT_WIDTH  read pointer
metering_in  in  NUM_CHANNELS*8  centre metering, channel 0 in LSBs
histogram_in  in  NUM_CHANNELS*NUM_HISTOGRAM_BINS*8  bins, channel-major, bin 0 in LSBs
histogram_read_enable_out  out  1  one-cycle snapshot strobe

Behaviour:
- Reset: all outputs 0, state IDLE, snapshots, shadows and sticky error cleared.
- FSM IDLE -> ACTIVE on op_code_valid_in rising edge (start cycle). ACTIVE -> IDLE on falling edge (end cycle). Opcode is latched at start; op_code_in changes mid-transaction are ignored.
- Start cycle: histogram_read_enable_out = 1 for one cycle. metering_in, histogram_in and (bytes_available_in - bytes_read_out) are latched into snapshots. All reads in the transaction come from these snapshots.
- Read opcodes: response_out is registered and reflects operand_count_in one cycle later. response_valid_out is 1 from the cycle after start through the end cycle, then 0.
- 0x20 capture: pulses start_capture_out once per transaction in the cycle after start. bytes_read_out <= 0. If capture_busy_in = 1 at start: no pulse, bytes_read_out unchanged, sticky error set.
- 0x21 bytes available: BYTE_COUNT_WIDTH/8 bytes from the snapshot, MSB first.
- 0x22 read data: response_out = data_in. Each operand_valid_in rising edge increments bytes_read_out, saturating at bytes_available_in. The edge detector is a 2-flop history cleared at start.
- 0x23 zoom, 0x24 pan: 2 bytes, MSB first, written to a shadow. Committed to the output on the end cycle only if exactly 2 operand bytes were received; otherwise the output is unchanged and the sticky error is set.
- 0x26 compression: 1 byte. The low COMPRESSION_WIDTH bits are committed on the end cycle if at least 1 byte was received.
- 0x25 metering: index i < NUM_CHANNELS returns channel i.
- 0x27 histogram: index = channel*NUM_HISTOGRAM_BINS + bin.
- 0x28 status: byte 0 = {6'b0, sticky_error, capture_busy_in}. The sticky error clears on the end cycle of a 0x28 transaction.
- Out-of-range index on any read opcode: response 0x00.
- Unknown opcode: response 0xFF with response_valid_out = 1; no side effects.
- Start and end in the same cycle are impossible; a 1-cycle op_code_valid_in pulse runs start then end on consecutive cycles.
- reset_in mid-transaction: immediate return to IDLE, all outputs 0; the rest of the transaction is ignored until the next rising edge.
- Read, write and capture opcodes give deterministic responses whether or not operand_valid_in toggles.

Decomposition:
- camera_spi_pkg: opcode localparams (OP_CAPTURE=0x20 ... OP_STATUS=0x28), state enum {IDLE, ACTIVE}, response constants RESP_UNKNOWN=0xFF and RESP_RANGE=0x00.
- One sub-module: spi_write_shadow_register (parameter WIDTH, NUM_BYTES). Handles MSB-first assembly, received-byte count, commit on end with an exact-count check, and a count error flag. Instantiated for zoom, pan and compression.

Test Plan:
- Reset, then 0x20 with capture_busy_in=0 -> start_capture_out pulses once; bytes_read_out=0; a second 0x20 while busy=1 -> no pulse; 0x28 byte 0 = 0x03.
- bytes_available_in=0x0123, 0x21 over 2 bytes -> responses 0x01, 0x23; bytes_available_in changing mid-transaction does not alter the responses.
- bytes_available_in=3, 0x22 with 5 operand edges -> bytes_read_out = 1, 2, 3, 3, 3.
- 0x23 operands 0x12, 0x34 -> zoom_factor_out=0x1234 only after op_code_valid_in falls. 0x24 with one byte 0x56 -> pan_level_out unchanged and sticky error set.
- histogram_in changing every cycle, 0x27 index 9 -> returns the channel 1, bin 1 value latched at start; histogram_read_enable_out pulses exactly once; index 24 (3x8 config) -> 0x00.
- Opcode 0x7E -> response 0xFF, no output changes. reset_in asserted mid 0x23 -> all outputs 0, no commit.

Source files
------------

// File: rtl/camera_spi_pkg.sv
// Shared opcodes, response codes and transaction state for the camera SPI register file.
package camera_spi_pkg;

    localparam logic [7:0] OP_CAPTURE     = 8'h20;
    localparam logic [7:0] OP_BYTES_AVAIL = 8'h21;
    localparam logic [7:0] OP_READ_DATA   = 8'h22;
    localparam logic [7:0] OP_ZOOM        = 8'h23;
    localparam logic [7:0] OP_PAN         = 8'h24;
    localparam logic [7:0] OP_METERING    = 8'h25;
    localparam logic [7:0] OP_COMPRESSION = 8'h26;
    localparam logic [7:0] OP_HISTOGRAM   = 8'h27;
    localparam logic [7:0] OP_STATUS      = 8'h28;

    localparam logic [7:0] RESP_UNKNOWN = 8'hFF;
    localparam logic [7:0] RESP_RANGE   = 8'h00;

    typedef enum logic {IDLE, ACTIVE} state_t;

endpackage

// File: rtl/spi_write_shadow_register.sv
// Assembles an MSB-first multi-byte SPI write in a shadow and commits it atomically
// at the end of the transaction when the received byte count is acceptable.
module spi_write_shadow_register #(
    parameter int WIDTH       = 16,
    parameter int NUM_BYTES   = 2,
    parameter bit EXACT_COUNT = 1'b1
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             i_clear,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    input  logic             i_commit,
    output logic [WIDTH-1:0] o_value,
    output logic             o_count_error
);

    localparam int SHADOW_W = NUM_BYTES * 8;
    localparam int CNT_W    = $clog2(NUM_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(NUM_BYTES + 1);

    logic [SHADOW_W-1:0] r_shadow;
    logic [CNT_W-1:0]    r_count;
    logic                w_count_ok;

    // Non-exact registers (single-byte settings) accept any non-empty write; the last byte wins.
    assign w_count_ok    = EXACT_COUNT ? (r_count == CNT_FULL) : (r_count != '0);
    assign o_count_error = i_commit && EXACT_COUNT && !w_count_ok;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_shadow <= '0;
            r_count  <= '0;
            o_value  <= '0;
        end else begin
            if (i_clear) begin
                r_shadow <= '0;
                r_count  <= '0;
            end else if (i_byte_valid) begin
                r_shadow <= (r_shadow << 8) | SHADOW_W'(i_byte);
                if (r_count != CNT_OVER) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
            if (i_commit && w_count_ok) begin
                o_value <= r_shadow[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/camera_spi_register_file.sv
// SPI register file between the opcode/operand deframer and the camera pipeline:
// coherent statistics snapshots, atomic multi-byte writes, capture control and status.
module camera_spi_register_file
    import camera_spi_pkg::*;
#(
    parameter int BYTE_COUNT_WIDTH    = 16,
    parameter int NUM_CHANNELS        = 3,
    parameter int NUM_HISTOGRAM_BINS  = 8,
    parameter int OPERAND_COUNT_WIDTH = 8,
    parameter int COMPRESSION_WIDTH   = 4
) (
    input  logic                                         clock_in,
    input  logic                                         reset_in,
    input  logic [7:0]                                   op_code_in,
    input  logic                                         op_code_valid_in,
    input  logic [7:0]                                   operand_in,
    input  logic                                         operand_valid_in,
    input  logic [OPERAND_COUNT_WIDTH-1:0]               operand_count_in,
    output logic [7:0]                                   response_out,
    output logic                                         response_valid_out,
    output logic                                         start_capture_out,
    input  logic                                         capture_busy_in,
    output logic [COMPRESSION_WIDTH-1:0]                 compression_factor_out,
    output logic [15:0]                                  zoom_factor_out,
    output logic [15:0]                                  pan_level_out,
    input  logic [BYTE_COUNT_WIDTH-1:0]                  bytes_available_in,
    input  logic [7:0]                                   data_in,
    output logic [BYTE_COUNT_WIDTH-1:0]                  bytes_read_out,
    input  logic [NUM_CHANNELS*8-1:0]                    metering_in,
    input  logic [NUM_CHANNELS*NUM_HISTOGRAM_BINS*8-1:0] histogram_in,
    output logic                                         histogram_read_enable_out
);

    localparam int NUM_COUNT_BYTES = BYTE_COUNT_WIDTH / 8;
    localparam int NUM_BINS_TOTAL  = NUM_CHANNELS * NUM_HISTOGRAM_BINS;

    state_t                          r_state, w_state_next;
    logic                            r_op_valid_d;
    logic [7:0]                      r_opcode;
    logic [1:0]                      r_opv_hist;
    logic [7:0]                      r_operand_d;
    logic                            r_sticky_error;
    logic [NUM_CHANNELS*8-1:0]       r_meter_snap;
    logic [NUM_BINS_TOTAL*8-1:0]     r_hist_snap;
    logic [BYTE_COUNT_WIDTH-1:0]     r_avail_snap;

    logic                            w_start, w_end, w_opv_rise;
    logic [7:0]                      w_eff_opcode, w_response;
    logic [NUM_CHANNELS*8-1:0]       w_meter_src;
    logic [NUM_BINS_TOTAL*8-1:0]     w_hist_src;
    logic [BYTE_COUNT_WIDTH-1:0]     w_avail_live, w_avail_src;
    logic [31:0]                     w_index;
    logic                            w_zoom_err, w_pan_err, w_comp_err;

    assign w_start    = (r_state == IDLE) && op_code_valid_in && !r_op_valid_d;
    assign w_end      = (r_state == ACTIVE) && !op_code_valid_in;
    assign w_opv_rise = (r_state == ACTIVE) && r_opv_hist[0] && !r_opv_hist[1];

    // In the start cycle the snapshot is still being loaded, so reads look through to the live inputs.
    assign w_avail_live = bytes_available_in - bytes_read_out;
    assign w_avail_src  = w_start ? w_avail_live : r_avail_snap;
    assign w_meter_src  = w_start ? metering_in  : r_meter_snap;
    assign w_hist_src   = w_start ? histogram_in : r_hist_snap;
    assign w_eff_opcode = w_start ? op_code_in   : r_opcode;
    assign w_index      = 32'(operand_count_in);

    always_ff @(posedge clock_in) begin
        if (reset_in) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = ACTIVE;
            ACTIVE:  if (w_end)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_response = RESP_RANGE;
        case (w_eff_opcode)
            OP_BYTES_AVAIL:
                for (int b = 0; b < NUM_COUNT_BYTES; b++)
                    if (w_index == 32'(b)) w_response = w_avail_src[(NUM_COUNT_BYTES-1-b)*8 +: 8];
            OP_READ_DATA:
                w_response = data_in;
            OP_METERING:
                for (int c = 0; c < NUM_CHANNELS; c++)
                    if (w_index == 32'(c)) w_response = w_meter_src[c*8 +: 8];
            OP_HISTOGRAM:
                for (int h = 0; h < NUM_BINS_TOTAL; h++)
                    if (w_index == 32'(h)) w_response = w_hist_src[h*8 +: 8];
            OP_STATUS:
                if (w_index == 32'd0) w_response = {6'b0, r_sticky_error, capture_busy_in};
            OP_CAPTURE, OP_ZOOM, OP_PAN, OP_COMPRESSION:
                w_response = RESP_RANGE;
            default:
                w_response = RESP_UNKNOWN;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            // Tracking the live level means a transaction cut by reset cannot restart until a fresh rising edge.
            r_op_valid_d              <= op_code_valid_in;
            r_opcode                  <= '0;
            r_opv_hist                <= '0;
            r_operand_d               <= '0;
            r_sticky_error            <= 1'b0;
            r_meter_snap              <= '0;
            r_hist_snap               <= '0;
            r_avail_snap              <= '0;
            response_out              <= '0;
            response_valid_out        <= 1'b0;
            start_capture_out         <= 1'b0;
            histogram_read_enable_out <= 1'b0;
            bytes_read_out            <= '0;
        end else begin
            r_op_valid_d              <= op_code_valid_in;
            r_opv_hist                <= {r_opv_hist[0], operand_valid_in};
            r_operand_d               <= operand_in;
            start_capture_out         <= 1'b0;
            histogram_read_enable_out <= 1'b0;
            if (w_start) begin
                r_opcode                  <= op_code_in;
                r_opv_hist                <= '0;
                r_meter_snap              <= metering_in;
                r_hist_snap               <= histogram_in;
                r_avail_snap              <= w_avail_live;
                histogram_read_enable_out <= 1'b1;
                response_valid_out        <= 1'b1;
                response_out              <= w_response;
                if (op_code_in == OP_CAPTURE) begin
                    if (capture_busy_in) begin
                        r_sticky_error <= 1'b1;
                    end else begin
                        start_capture_out <= 1'b1;
                        bytes_read_out    <= '0;
                    end
                end
            end else if (r_state == ACTIVE) begin
                if (w_end) begin
                    response_valid_out <= 1'b0;
                    response_out       <= '0;
                    if (r_opcode == OP_STATUS)                   r_sticky_error <= 1'b0;
                    else if (w_zoom_err || w_pan_err || w_comp_err) r_sticky_error <= 1'b1;
                end else begin
                    response_valid_out <= 1'b1;
                    response_out       <= w_response;
                end
                if (w_opv_rise && (r_opcode == OP_READ_DATA) && (bytes_read_out < bytes_available_in)) begin
                    bytes_read_out <= bytes_read_out + BYTE_COUNT_WIDTH'(1);
                end
            end
        end
    end

    spi_write_shadow_register #(.WIDTH(16), .NUM_BYTES(2), .EXACT_COUNT(1'b1)) u_zoom (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .i_clear       (w_start),
        .i_byte_valid  (w_opv_rise && (r_opcode == OP_ZOOM)),
        .i_byte        (r_operand_d),
        .i_commit      (w_end && (r_opcode == OP_ZOOM)),
        .o_value       (zoom_factor_out),
        .o_count_error (w_zoom_err)
    );

    spi_write_shadow_register #(.WIDTH(16), .NUM_BYTES(2), .EXACT_COUNT(1'b1)) u_pan (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .i_clear       (w_start),
        .i_byte_valid  (w_opv_rise && (r_opcode == OP_PAN)),
        .i_byte        (r_operand_d),
        .i_commit      (w_end && (r_opcode == OP_PAN)),
        .o_value       (pan_level_out),
        .o_count_error (w_pan_err)
    );

    spi_write_shadow_register #(.WIDTH(COMPRESSION_WIDTH), .NUM_BYTES(1), .EXACT_COUNT(1'b0)) u_compression (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .i_clear       (w_start),
        .i_byte_valid  (w_opv_rise && (r_opcode == OP_COMPRESSION)),
        .i_byte        (r_operand_d),
        .i_commit      (w_end && (r_opcode == OP_COMPRESSION)),
        .o_value       (compression_factor_out),
        .o_count_error (w_comp_err)
    );

endmodule

// File: tb/tb_camera_spi_register_file.sv
// Scoreboard bench: stimulus pushes expected response bytes from a behavioural model,
// a negedge monitor pops and compares whenever response_valid_out is high.
module tb_camera_spi_register_file;
    import camera_spi_pkg::*;

    localparam int BCW = 16;
    localparam int NC  = 3;
    localparam int NB  = 8;
    localparam int OCW = 8;
    localparam int CW  = 4;

    logic              clock_in = 1'b0;
    logic              reset_in;
    logic [7:0]        op_code_in;
    logic              op_code_valid_in;
    logic [7:0]        operand_in;
    logic              operand_valid_in;
    logic [OCW-1:0]    operand_count_in;
    logic [7:0]        response_out;
    logic              response_valid_out;
    logic              start_capture_out;
    logic              capture_busy_in;
    logic [CW-1:0]     compression_factor_out;
    logic [15:0]       zoom_factor_out;
    logic [15:0]       pan_level_out;
    logic [BCW-1:0]    bytes_available_in;
    logic [7:0]        data_in;
    logic [BCW-1:0]    bytes_read_out;
    logic [NC*8-1:0]   metering_in;
    logic [NC*NB*8-1:0] histogram_in;
    logic              histogram_read_enable_out;

    always #5 clock_in = ~clock_in;

    camera_spi_register_file #(
        .BYTE_COUNT_WIDTH(BCW), .NUM_CHANNELS(NC), .NUM_HISTOGRAM_BINS(NB),
        .OPERAND_COUNT_WIDTH(OCW), .COMPRESSION_WIDTH(CW)
    ) dut (
        .clock_in(clock_in), .reset_in(reset_in),
        .op_code_in(op_code_in), .op_code_valid_in(op_code_valid_in),
        .operand_in(operand_in), .operand_valid_in(operand_valid_in),
        .operand_count_in(operand_count_in),
        .response_out(response_out), .response_valid_out(response_valid_out),
        .start_capture_out(start_capture_out), .capture_busy_in(capture_busy_in),
        .compression_factor_out(compression_factor_out),
        .zoom_factor_out(zoom_factor_out), .pan_level_out(pan_level_out),
        .bytes_available_in(bytes_available_in), .data_in(data_in),
        .bytes_read_out(bytes_read_out), .metering_in(metering_in),
        .histogram_in(histogram_in), .histogram_read_enable_out(histogram_read_enable_out)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    int         cap_pulses  = 0;
    int         hist_pulses = 0;

    // Behavioural model state
    logic [15:0] m_zoom, m_pan, m_ptr, m_avail;
    logic [3:0]  m_comp;
    logic        m_sticky, m_in_txn, m_prev_valid;
    logic [7:0]  m_op;
    logic [7:0]  m_meter[NC];
    logic [7:0]  m_hist[NC*NB];
    logic [7:0]  m_bytes[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock_in) begin
        if (start_capture_out === 1'b1) cap_pulses++;
        if (histogram_read_enable_out === 1'b1) hist_pulses++;
        if (response_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL resp_unexpected: got 0x%0h expected no response at %0t", response_out, $time);
            end else begin
                check("response", 32'(response_out), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic void model_reset();
        m_zoom = '0; m_pan = '0; m_comp = '0; m_ptr = '0; m_avail = '0;
        m_sticky = 1'b0; m_in_txn = 1'b0; m_op = '0;
        m_bytes.delete();
    endfunction

    function automatic void model_start();
        m_in_txn = 1'b1;
        m_op     = op_code_in;
        m_bytes.delete();
        for (int c = 0; c < NC; c++)    m_meter[c] = metering_in[8*c +: 8];
        for (int h = 0; h < NC*NB; h++) m_hist[h]  = histogram_in[8*h +: 8];
        m_avail = bytes_available_in - m_ptr;
        if (op_code_in == OP_CAPTURE) begin
            if (capture_busy_in) m_sticky = 1'b1;
            else                 m_ptr = '0;
        end
    endfunction

    function automatic void model_end();
        m_in_txn = 1'b0;
        case (m_op)
            OP_ZOOM:        if (m_bytes.size() == 2) m_zoom = {m_bytes[0], m_bytes[1]}; else m_sticky = 1'b1;
            OP_PAN:         if (m_bytes.size() == 2) m_pan  = {m_bytes[0], m_bytes[1]}; else m_sticky = 1'b1;
            OP_COMPRESSION: if (m_bytes.size() >= 1) m_comp = m_bytes[m_bytes.size()-1][3:0];
            OP_STATUS:      m_sticky = 1'b0;
            default: ;
        endcase
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_op == OP_READ_DATA) begin
            if (m_ptr < bytes_available_in) m_ptr = m_ptr + 16'd1;
        end else begin
            m_bytes.push_back(b);
        end
    endfunction

    function automatic logic [7:0] model_resp();
        int          idx = int'(operand_count_in);
        logic [15:0] t;
        case (m_op)
            OP_BYTES_AVAIL: begin
                if (idx >= BCW/8) return 8'h00;
                t = m_avail >> (8 * (BCW/8 - 1 - idx));
                return t[7:0];
            end
            OP_READ_DATA:  return data_in;
            OP_METERING:   return (idx < NC) ? m_meter[idx] : 8'h00;
            OP_HISTOGRAM:  return (idx < NC*NB) ? m_hist[idx] : 8'h00;
            OP_STATUS:     return (idx == 0) ? {6'b0, m_sticky, capture_busy_in} : 8'h00;
            OP_CAPTURE, OP_ZOOM, OP_PAN, OP_COMPRESSION: return 8'h00;
            default:       return 8'hFF;
        endcase
    endfunction

    // One clock: update the model for the coming edge, enqueue its expected response, advance.
    task automatic step();
        if (reset_in) begin
            model_reset();
            m_prev_valid = op_code_valid_in;
        end else begin
            if (op_code_valid_in && !m_prev_valid && !m_in_txn) model_start();
            else if (!op_code_valid_in && m_in_txn)             model_end();
            m_prev_valid = op_code_valid_in;
            if (m_in_txn && op_code_valid_in) exp_q.push_back(model_resp());
        end
        @(posedge clock_in);
        #1;
        data_in     = 8'($urandom);
        metering_in = NC*8'($urandom);
        for (int h = 0; h < NC*NB; h++) histogram_in[8*h +: 8] = 8'($urandom);
    endtask

    // Full transaction: read indices idx_lo..idx_hi, then n_bytes operand edges (byte k = wdata[8k+:8]).
    task automatic txn(input logic [7:0] op, input int idx_lo, input int idx_hi,
                       input int n_bytes, input logic [31:0] wdata);
        int   caps0;
        int   hists0;
        logic busy0;
        caps0  = cap_pulses;
        hists0 = hist_pulses;
        busy0  = capture_busy_in;
        op_code_in       = op;
        op_code_valid_in = 1'b1;
        operand_count_in = OCW'(idx_lo);
        step();
        op_code_in = 8'($urandom);
        if (op == OP_BYTES_AVAIL) bytes_available_in = BCW'($urandom);
        for (int i = idx_lo; i <= idx_hi; i++) begin
            operand_count_in = OCW'(i);
            step();
            step();
        end
        for (int k = 0; k < n_bytes; k++) begin
            operand_count_in = OCW'(k);
            operand_in       = wdata[8*k +: 8];
            operand_valid_in = 1'b1;
            model_byte(operand_in);
            step();
            step();
            operand_valid_in = 1'b0;
            step();
            step();
            if (op == OP_READ_DATA) check("bytes_read_step", 32'(bytes_read_out), 32'(m_ptr));
        end
        step();
        check("zoom_hold", 32'(zoom_factor_out), 32'(m_zoom));
        check("pan_hold", 32'(pan_level_out), 32'(m_pan));
        check("comp_hold", 32'(compression_factor_out), 32'(m_comp));
        op_code_valid_in = 1'b0;
        step();
        step();
        check("zoom", 32'(zoom_factor_out), 32'(m_zoom));
        check("pan", 32'(pan_level_out), 32'(m_pan));
        check("comp", 32'(compression_factor_out), 32'(m_comp));
        check("bytes_read", 32'(bytes_read_out), 32'(m_ptr));
        check("capture_pulses", 32'(cap_pulses - caps0), (op == OP_CAPTURE && !busy0) ? 32'd1 : 32'd0);
        check("hist_strobe", 32'(hist_pulses - hists0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops[10];
        logic [7:0] op;
        ops = '{OP_CAPTURE, OP_BYTES_AVAIL, OP_READ_DATA, OP_ZOOM, OP_PAN,
                OP_METERING, OP_COMPRESSION, OP_HISTOGRAM, OP_STATUS, 8'h7E};
        reset_in = 1'b1;
        op_code_in = '0; op_code_valid_in = 1'b0;
        operand_in = '0; operand_valid_in = 1'b0; operand_count_in = '0;
        capture_busy_in = 1'b0; bytes_available_in = '0; data_in = '0;
        metering_in = '0; histogram_in = '0;
        model_reset();
        m_prev_valid = 1'b0;
        repeat (3) step();
        reset_in = 1'b0;
        step();

        check("rst_response", 32'(response_out), 32'd0);
        check("rst_resp_valid", 32'(response_valid_out), 32'd0);
        check("rst_start_capture", 32'(start_capture_out), 32'd0);
        check("rst_zoom", 32'(zoom_factor_out), 32'd0);
        check("rst_pan", 32'(pan_level_out), 32'd0);
        check("rst_comp", 32'(compression_factor_out), 32'd0);
        check("rst_bytes_read", 32'(bytes_read_out), 32'd0);
        check("rst_hist_en", 32'(histogram_read_enable_out), 32'd0);

        capture_busy_in = 1'b0;
        txn(OP_CAPTURE, 0, 1, 0, 0);
        capture_busy_in = 1'b1;
        txn(OP_CAPTURE, 0, 1, 0, 0);
        txn(OP_STATUS, 0, 1, 0, 0);
        capture_busy_in = 1'b0;

        bytes_available_in = 16'h0123;
        txn(OP_BYTES_AVAIL, 0, 2, 0, 0);

        bytes_available_in = 16'd3;
        txn(OP_READ_DATA, 0, 0, 5, $urandom);

        txn(OP_ZOOM, 0, 0, 2, 32'h0000_3412);
        check("zoom_1234", 32'(zoom_factor_out), 32'h1234);
        txn(OP_PAN, 0, 0, 1, 32'h0000_0056);
        txn(OP_STATUS, 0, 0, 0, 0);

        txn(OP_HISTOGRAM, 8, 10, 0, 0);
        txn(OP_HISTOGRAM, 23, 25, 0, 0);
        txn(OP_METERING, 0, 3, 0, 0);
        txn(OP_COMPRESSION, 0, 0, 1, $urandom);
        txn(8'h7E, 0, 2, 0, 0);
        txn(OP_ZOOM, 0, 0, 2, $urandom);

        // Reset in the middle of a zoom write: everything clears and the tail is ignored.
        op_code_in = OP_ZOOM;
        op_code_valid_in = 1'b1;
        operand_count_in = '0;
        step();
        operand_in = 8'hAB;
        operand_valid_in = 1'b1;
        model_byte(operand_in);
        step();
        step();
        operand_valid_in = 1'b0;
        reset_in = 1'b1;
        step();
        step();
        reset_in = 1'b0;
        step();
        step();
        check("midrst_resp_valid", 32'(response_valid_out), 32'd0);
        check("midrst_zoom", 32'(zoom_factor_out), 32'd0);
        check("midrst_pan", 32'(pan_level_out), 32'd0);
        check("midrst_comp", 32'(compression_factor_out), 32'd0);
        check("midrst_bytes_read", 32'(bytes_read_out), 32'd0);
        operand_in = 8'hCD;
        operand_valid_in = 1'b1;
        step();
        step();
        operand_valid_in = 1'b0;
        op_code_valid_in = 1'b0;
        step();
        step();
        check("midrst_no_commit", 32'(zoom_factor_out), 32'd0);
        check("midrst_hist_en", 32'(histogram_read_enable_out), 32'd0);

        for (int t = 0; t < 30; t++) begin
            int lo;
            op = ops[$urandom_range(0, 9)];
            if (op == 8'h7E) op = 8'($urandom_range(8'h29, 8'hFF));
            capture_busy_in = 1'($urandom);
            if (op == OP_READ_DATA) bytes_available_in = BCW'($urandom_range(0, 6));
            lo = $urandom_range(0, 26);
            txn(op, lo, lo + $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
        end

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
